// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) arbiter onto one shared memory port
// Request bus layout {valid, instr, addr, wdata, wstrb}; response bus layout {rdata, ready}.
module mem_arbiter #(
   parameter int priority_mode = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [69:0] iport_in,
   output logic [32:0] iport_out,
   input  logic [69:0] dport_in,
   output logic [32:0] dport_out,
   output logic [69:0] mem_in,
   input  logic [32:0] mem_out
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   state_t      state, state_nx;
   logic        ipend, dpend, ipend_nx, dpend_nx;
   logic [68:0] ipend_req, dpend_req, ipend_req_nx, dpend_req_nx;
   logic        last_grant, last_grant_nx;
   logic        fresh, fresh_nx;
   logic        mem_valid, mem_valid_nx;
   logic [68:0] mem_req, mem_req_nx;

   logic        mem_ready;
   logic        i_pulse, d_pulse, i_want, d_want, pick_d;
   logic [68:0] i_req, d_req;

   assign mem_ready = mem_out[0];

   // A port with a pending or in-flight request drops further pulses.
   assign i_pulse = iport_in[69] && !ipend && (state != IBUSY);
   assign d_pulse = dport_in[69] && !dpend && (state != DBUSY);
   assign i_want  = ipend || i_pulse;
   assign d_want  = dpend || d_pulse;
   assign i_req   = ipend ? ipend_req : iport_in[68:0];
   assign d_req   = dpend ? dpend_req : dport_in[68:0];

   // last_grant: 1 = data. Until the first grant completes, data wins ties.
   always_comb begin
      pick_d = 1'b0;
      if (priority_mode == 1)
         pick_d = d_want;
      else
         pick_d = d_want && (!i_want || fresh || !last_grant);
   end

   always_comb begin
      state_nx      = state;
      ipend_nx      = ipend;
      dpend_nx      = dpend;
      ipend_req_nx  = ipend_req;
      dpend_req_nx  = dpend_req;
      last_grant_nx = last_grant;
      fresh_nx      = fresh;
      mem_valid_nx  = 1'b0;
      mem_req_nx    = mem_req;

      if (i_pulse) begin
         ipend_nx     = 1'b1;
         ipend_req_nx = iport_in[68:0];
      end
      if (d_pulse) begin
         dpend_nx     = 1'b1;
         dpend_req_nx = dport_in[68:0];
      end

      case (state)
         IDLE: begin
            if (i_want || d_want) begin
               mem_valid_nx = 1'b1;
               if (pick_d) begin
                  state_nx   = DBUSY;
                  dpend_nx   = 1'b0;
                  mem_req_nx = d_req;
               end else begin
                  state_nx   = IBUSY;
                  ipend_nx   = 1'b0;
                  mem_req_nx = i_req;
               end
            end
         end
         IBUSY: begin
            if (mem_ready) begin
               state_nx      = IDLE;
               last_grant_nx = 1'b0;
               fresh_nx      = 1'b0;
               mem_req_nx    = '0;
            end
         end
         DBUSY: begin
            if (mem_ready) begin
               state_nx      = IDLE;
               last_grant_nx = 1'b1;
               fresh_nx      = 1'b0;
               mem_req_nx    = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         ipend      <= 1'b0;
         dpend      <= 1'b0;
         ipend_req  <= '0;
         dpend_req  <= '0;
         last_grant <= 1'b1;
         fresh      <= 1'b1;
         mem_valid  <= 1'b0;
         mem_req    <= '0;
      end else begin
         state      <= state_nx;
         ipend      <= ipend_nx;
         dpend      <= dpend_nx;
         ipend_req  <= ipend_req_nx;
         dpend_req  <= dpend_req_nx;
         last_grant <= last_grant_nx;
         fresh      <= fresh_nx;
         mem_valid  <= mem_valid_nx;
         mem_req    <= mem_req_nx;
      end
   end

   assign mem_in    = {mem_valid, mem_req};
   assign iport_out = (state == IBUSY && mem_ready) ? {mem_out[32:1], 1'b1} : 33'd0;
   assign dport_out = (state == DBUSY && mem_ready) ? {mem_out[32:1], 1'b1} : 33'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven bench for mem_arbiter (round-robin and fixed-priority instances)
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [69:0] iport_in = '0;
   logic [69:0] dport_in = '0;
   logic [32:0] mem_out = '0;
   logic [32:0] rr_iport_out, rr_dport_out, fp_iport_out, fp_dport_out;
   logic [69:0] rr_mem_in, fp_mem_in;

   always #5 clock = ~clock;

   mem_arbiter #(.priority_mode(0)) u_rr (
      .clock(clock), .reset(reset),
      .iport_in(iport_in), .iport_out(rr_iport_out),
      .dport_in(dport_in), .dport_out(rr_dport_out),
      .mem_in(rr_mem_in), .mem_out(mem_out)
   );

   mem_arbiter #(.priority_mode(1)) u_fp (
      .clock(clock), .reset(reset),
      .iport_in(iport_in), .iport_out(fp_iport_out),
      .dport_in(dport_in), .dport_out(fp_dport_out),
      .mem_in(fp_mem_in), .mem_out(mem_out)
   );

   typedef struct {
      logic        pre;
      logic        fp;
      logic        rst;
      logic        iv;
      logic [31:0] ia;
      logic        dv;
      logic [31:0] da;
      logic [31:0] dw;
      logic [3:0]  ds;
      logic        mr;
      logic [31:0] md;
      logic        ev;
      logic        ei;
      logic [31:0] ea;
      logic [31:0] ewd;
      logic [3:0]  ews;
      logic        ir;
      logic [31:0] id;
      logic        dr;
      logic [31:0] dd;
      logic        z;
   } vec_t;

   vec_t tbl[$];
   vec_t cur;
   int   checks = 0;
   int   errors = 0;

   task automatic s(input logic pre, fp, rst, iv, input logic [31:0] ia, input logic dv,
                    input logic [31:0] da, dw, input logic [3:0] ds, input logic mr, input logic [31:0] md);
      cur.pre = pre; cur.fp = fp; cur.rst = rst; cur.iv = iv; cur.ia = ia; cur.dv = dv;
      cur.da = da; cur.dw = dw; cur.ds = ds; cur.mr = mr; cur.md = md;
   endtask

   task automatic e(input logic ev, ei, input logic [31:0] ea, ewd, input logic [3:0] ews,
                    input logic ir, input logic [31:0] id, input logic dr, input logic [31:0] dd, input logic z);
      cur.ev = ev; cur.ei = ei; cur.ea = ea; cur.ewd = ewd; cur.ews = ews;
      cur.ir = ir; cur.id = id; cur.dr = dr; cur.dd = dd; cur.z = z;
      tbl.push_back(cur);
   endtask

   task automatic chk(input string nm, input int row, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      iport_in = '0;
      dport_in = '0;
      mem_out = '0;
      @(posedge clock);
   endtask

   task automatic build();
      // Single read, latency and one-cycle mem_valid / ready
      s(1,0,0, 0,0,          0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 1);
      s(0,0,0, 1,32'h100,    0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(1,1,32'h100,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 1,32'hDEADBEEF);      e(0,0,0,0,0, 1,32'hDEADBEEF, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 1);
      // Simultaneous pulses after reset: data first, instruction 2 cycles after data ready
      s(1,0,0, 1,32'h10,     1,32'h20,0,0, 0,0);            e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(1,0,32'h20,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 1,32'hAAAA0001);      e(0,0,0,0,0, 0,0, 1,32'hAAAA0001, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(1,1,32'h10,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 1,32'h55);            e(0,0,0,0,0, 1,32'h55, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 1);
      // Round-robin alternation D,I,D,I,D,I with the finished port re-pulsing
      s(1,0,0, 1,32'h10,     1,32'h20,0,0, 0,0);            e(0,0,0,0,0, 0,0, 0,0, 0);
      for (int g = 0; g < 6; g++) begin
         logic gi;
         gi = g[0];
         s(0,0,0, 0,0, 0,0,0,0, 0,0);
         e(1, gi, gi ? 32'h10 : 32'h20, 0,0, 0,0, 0,0, 0);
         s(0,0,0, 0,0, 0,0,0,0, 1, 32'h1000 + g);
         e(0,0,0,0,0, gi, gi ? 32'h1000 + g : 32'h0, !gi, gi ? 32'h0 : 32'h1000 + g, 0);
         s(0,0,0, gi, gi ? 32'h10 : 32'h0, !gi, gi ? 32'h0 : 32'h20, 0,0, 0,0);
         e(0,0,0,0,0, 0,0, 0,0, 0);
      end
      // Fixed data priority: data wins every tie while it keeps requesting
      s(1,1,0, 1,32'h10,     1,32'h20,0,0, 0,0);            e(0,0,0,0,0, 0,0, 0,0, 0);
      for (int g = 0; g < 3; g++) begin
         s(0,1,0, 0,0, 0,0,0,0, 0,0);
         e(1,0,32'h20,0,0, 0,0, 0,0, 0);
         s(0,1,0, 0,0, 0,0,0,0, 1, 32'h2000 + g);
         e(0,0,0,0,0, 0,0, 1, 32'h2000 + g, 0);
         s(0,1,0, 0,0, (g < 2), (g < 2) ? 32'h20 : 32'h0, 0,0, 0,0);
         e(0,0,0,0,0, 0,0, 0,0, 0);
      end
      s(0,1,0, 0,0,          0,0,0,0, 0,0);                 e(1,1,32'h10,0,0, 0,0, 0,0, 0);
      s(0,1,0, 0,0,          0,0,0,0, 1,32'h77);            e(0,0,0,0,0, 1,32'h77, 0,0, 0);
      // Buffered data write while IBUSY; second pulse while pending is dropped
      s(1,0,0, 1,32'h300,    0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          1,32'h200,32'h12345678,4'hF, 0,0); e(1,1,32'h300,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          1,32'h204,32'hCAFEF00D,4'h3, 0,0); e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 1,32'h11);            e(0,0,0,0,0, 1,32'h11, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(1,0,32'h200,32'h12345678,4'hF, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 1,32'h22);            e(0,0,0,0,0, 0,0, 1,32'h22, 0);
      for (int k = 0; k < 3; k++) begin
         s(0,0,0, 0,0, 0,0,0,0, 0,0);
         e(0,0,0,0,0, 0,0, 0,0, 1);
      end
      // Reset mid-transaction; pulse during reset and later ready are ignored
      s(1,0,0, 1,32'h400,    0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(1,1,32'h400,0,0, 0,0, 0,0, 0);
      s(0,0,1, 0,0,          1,32'h600,0,0, 0,0);           e(0,0,0,0,0, 0,0, 0,0, 0);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(0,0,0,0,0, 0,0, 0,0, 1);
      s(0,0,0, 0,0,          0,0,0,0, 1,32'h99);            e(0,0,0,0,0, 0,0, 0,0, 1);
      s(0,0,0, 0,0,          1,32'h500,0,0, 0,0);           e(0,0,0,0,0, 0,0, 0,0, 1);
      s(0,0,0, 0,0,          0,0,0,0, 0,0);                 e(1,0,32'h500,0,0, 0,0, 0,0, 0);
      // Stray ready while idle
      s(1,0,0, 0,0,          0,0,0,0, 1,32'hFFFFFFFF);      e(0,0,0,0,0, 0,0, 0,0, 1);
      s(0,0,0, 0,0,          0,0,0,0, 1,32'h0BADF00D);      e(0,0,0,0,0, 0,0, 0,0, 1);
   endtask

   initial begin
      logic [69:0] mi;
      logic [32:0] io, dout;
      build();
      for (int k = 0; k < tbl.size(); k++) begin
         if (tbl[k].pre) do_reset();
         @(posedge clock);
         #1;
         reset    = tbl[k].rst;
         iport_in = {tbl[k].iv, 1'b1, tbl[k].ia, 32'h0, 4'h0};
         dport_in = {tbl[k].dv, 1'b0, tbl[k].da, tbl[k].dw, tbl[k].ds};
         mem_out  = {tbl[k].md, tbl[k].mr};
         @(negedge clock);
         mi   = tbl[k].fp ? fp_mem_in    : rr_mem_in;
         io   = tbl[k].fp ? fp_iport_out : rr_iport_out;
         dout = tbl[k].fp ? fp_dport_out : rr_dport_out;
         chk("mem_valid", k, {69'd0, mi[69]}, {69'd0, tbl[k].ev});
         if (tbl[k].ev) begin
            chk("mem_instr", k, {69'd0, mi[68]}, {69'd0, tbl[k].ei});
            chk("mem_addr",  k, {38'd0, mi[67:36]}, {38'd0, tbl[k].ea});
            chk("mem_wdata", k, {38'd0, mi[35:4]},  {38'd0, tbl[k].ewd});
            chk("mem_wstrb", k, {66'd0, mi[3:0]},   {66'd0, tbl[k].ews});
         end else if (tbl[k].z) begin
            chk("mem_in_zero", k, mi, 70'd0);
         end
         chk("iport_ready", k, {69'd0, io[0]},      {69'd0, tbl[k].ir});
         chk("iport_rdata", k, {38'd0, io[32:1]},   {38'd0, tbl[k].id});
         chk("dport_ready", k, {69'd0, dout[0]},    {69'd0, tbl[k].dr});
         chk("dport_rdata", k, {38'd0, dout[32:1]}, {38'd0, tbl[k].dd});
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: priority_mode, default 0, 0 = round-robin between ports, 1 = fixed data-port priority.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: iport_in  input  mem_in_type (70)  instruction-side request: valid, instr, addr[31:0], wdata[31:0], wstrb[3:0].
REQ-005 Port: iport_out  output  mem_out_type (33)  instruction-side response: rdata[31:0], ready.
REQ-006 Port: dport_in  input  mem_in_type (70)  data-side request, same fields as iport_in.
REQ-007 Port: dport_out  output  mem_out_type (33)  data-side response.
REQ-008 Port: mem_in  output  mem_in_type (70)  request to the shared external memory.
REQ-009 Port: mem_out  input  mem_out_type (33)  shared external memory response.

Function
REQ-010 A request is a single-cycle pulse of mem_valid; each port has one pending register of 69 bits (instr, addr, wdata, wstrb) plus a pending flag, captured on that pulse.
REQ-011 A port with its pending flag set or with its request in flight ignores further valid pulses from that port; no overwrite, no response for the dropped pulse.
REQ-012 FSM states: IDLE, IBUSY, DBUSY.
REQ-013 IDLE: if any pending flag is set, or a valid pulse arrives this cycle, select a winner, move to IBUSY or DBUSY next cycle, and clear the winner's pending flag.
REQ-014 Winner selection, priority_mode=0: both requesting -> the port not granted last (last_grant register, reset value = data); only one requesting -> that port.
REQ-015 Winner selection, priority_mode=1: data port always wins a tie.
REQ-016 A grant decision counts pending flags and same-cycle valid pulses equally.
REQ-017 mem_in.mem_valid is registered; it is 1 for exactly the first cycle of IBUSY/DBUSY, with addr/wdata/wstrb/instr from the granted request.
REQ-018 mem_in fields hold the granted request's values until the grant ends; mem_valid is 0 in every other cycle.
REQ-019 Minimum latency: port valid in cycle N with the arbiter idle -> mem_in.mem_valid=1 in cycle N+1.
REQ-020 In IBUSY/DBUSY, mem_out.mem_ready=1 routes mem_out.mem_rdata combinationally to the granted port's rdata with ready=1 in the same cycle.
REQ-021 On that same mem_out.mem_ready=1, the FSM returns to IDLE and last_grant updates.
REQ-022 A new grant can therefore issue mem_valid at the earliest 2 cycles after the previous mem_ready.
REQ-023 The non-granted port's ready is 0, and its rdata is 0, in every cycle.
REQ-024 mem_out.mem_ready while in IDLE is ignored; no port sees ready.
REQ-025 A valid pulse arriving on the same cycle that port's in-flight request completes is ignored.
REQ-026 A valid pulse from the other port during a busy state is captured into its pending register.
REQ-027 Write requests (wstrb != 0) and reads are arbitrated identically; rdata is returned on writes as driven by memory.

Reset
REQ-028 While reset=1 at a clock edge: FSM -> IDLE, both pending flags and pending registers -> 0, last_grant -> data.
REQ-029 After that reset edge, mem_in, iport_out and dport_out are all 0.
REQ-030 Reset mid-transaction abandons the in-flight request; a later mem_ready is ignored.
REQ-031 Valid pulses coincident with reset=1 are discarded.

Verification
REQ-032 Single read: iport valid addr=0x100 in cycle 5, memory ready with rdata=0xDEADBEEF in cycle 8 -> mem_valid=1 in cycle 6 only; iport_out.ready=1, rdata=0xDEADBEEF in cycle 8 only.
REQ-033 Simultaneous pulses, mode 0, after reset: both ports valid in cycle 2 -> data granted first (mem_valid cycle 3), instruction issued 2 cycles after data's ready.
REQ-034 Round-robin alternation: both ports continuously re-request after each ready for 6 grants -> grant sequence D,I,D,I,D,I; priority_mode=1 -> all D while data keeps requesting.
REQ-035 Buffering: dport write addr=0x200 wdata=0x12345678 wstrb=0xF pulsed while IBUSY -> held, issued unchanged after instruction completes; a second dport pulse while pending is dropped (exactly one write on mem_in).
REQ-036 Reset mid-operation: reset in the cycle after mem_valid, mem_ready 2 cycles later -> no port ready, FSM IDLE, all outputs 0.
REQ-037 Stray ready: mem_ready=1 in IDLE -> iport_out and dport_out remain 0.
